modexp_ctrl: RTL and testbench

//  Left-to-right square-and-multiply controller for RSA modular exponentiation: result = X^E mod M.

---
 rtl/modexp_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer for X^E mod M around an external
// Montgomery multiplier. Optional: `define MODEXP_SKIP_LEADING_ZEROS_EN to skip leading zero bits of E.
module modexp_ctrl #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r2,
    input  logic [WIDTH-1:0]     in_r,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(EXP_WIDTH);
    localparam int IW = BW + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_MONT,
        S_SQUARE,
        S_MULT,
        S_NEXT,
        S_FROM_MONT,
        S_DONE
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        , S_SCAN
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH-1:0]     xt_q, xt_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mm_a_q, mm_a_d;
    logic [WIDTH-1:0]     mm_b_q, mm_b_d;
    logic [WIDTH-1:0]     mm_m_q, mm_m_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 mm_start_q, mm_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mm_done_q;
    logic                 e_bit;
    logic                 is_mm_d;
    logic                 mm_complete;

    assign e_bit = e_q[idx_q[BW-1:0]];

    // A stale-high mm_done never counts: completion needs a fresh rising edge after the pulse cycle.
    assign mm_complete = mm_done && !mm_done_q && !mm_start_q;

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        e_d      = e_q;
        r_d      = r_q;
        xt_d     = xt_q;
        acc_d    = acc_q;
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;
        mm_m_d   = mm_m_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    e_d     = in_e;
                    r_d     = in_r;
                    mm_m_d  = in_m;
                    idx_d   = IW'(EXP_WIDTH - 1);
                    state_d = S_TO_MONT;
                end
            end
            S_TO_MONT: begin
                if (mm_complete) begin
                    xt_d  = mm_result;
                    acc_d = r_q;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                    state_d = S_SCAN;
`else
                    state_d = S_SQUARE;
`endif
                end
            end
            S_SQUARE: begin
                if (mm_complete) begin
                    acc_d   = mm_result;
                    state_d = e_bit ? S_MULT : S_NEXT;
                end
            end
            S_MULT: begin
                if (mm_complete) begin
                    acc_d   = mm_result;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    state_d = S_FROM_MONT;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_SQUARE;
                end
            end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            // A still holds R (Montgomery 1), so the top set bit needs only its multiply.
            S_SCAN: begin
                if (e_bit) begin
                    state_d = S_MULT;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IW'(1);
                end else begin
                    state_d = S_FROM_MONT;
                end
            end
`endif
            S_FROM_MONT: begin
                if (mm_complete) begin
                    acc_d   = mm_result;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // X and R^2 feed only the first multiply, so the operand registers double as their latch.
        is_mm_d    = state_d inside {S_TO_MONT, S_SQUARE, S_MULT, S_FROM_MONT};
        mm_start_d = is_mm_d && (state_d != state_q);
        if (mm_start_d) begin
            case (state_d)
                S_TO_MONT: begin
                    mm_a_d = in_x;
                    mm_b_d = in_r2;
                end
                S_SQUARE: begin
                    mm_a_d = acc_d;
                    mm_b_d = acc_d;
                end
                S_MULT: begin
                    mm_a_d = acc_d;
                    mm_b_d = xt_d;
                end
                default: begin
                    mm_a_d = acc_d;
                    mm_b_d = ONE;
                end
            endcase
        end

        busy_d = !(state_d inside {S_IDLE, S_DONE});
        done_d = (state_d == S_DONE);
        if (done_d) begin
            result_d = acc_d;
        end
    end

    // NOTE: the wide datapath registers are reset as well, so every output is a defined zero after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            e_q        <= '0;
            r_q        <= '0;
            xt_q       <= '0;
            acc_q      <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
            result_q   <= '0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q    <= state_d;
            idx_q      <= idx_d;
            e_q        <= e_d;
            r_q        <= r_d;
            xt_q       <= xt_d;
            acc_q      <= acc_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_m_q     <= mm_m_d;
            result_q   <= result_d;
            mm_start_q <= mm_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mm_done_q  <= mm_done;
        end
    end

    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = mm_m_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: drives modexp_ctrl with a behavioural Montgomery multiplier (R = 2^WIDTH)
// and compares X^E mod M against a plain modular-exponentiation reference.
module tb_modexp_ctrl;

    localparam int W  = 1024;
    localparam int EW = 1024;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x, in_m, in_r2, in_r;
    logic [EW-1:0] in_e;
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic [W-1:0]  mm_result = '0;
    logic          mm_done = 1'b1;
    logic [W-1:0]  result;
    logic          busy, done;

    int tests    = 0;
    int fails    = 0;
    int pulses   = 0;
    int done_cnt = 0;
    int stab_err = 0;

    logic [W-1:0] cur_m, cur_mp;
    logic [W-1:0] pend_val, pend_a, pend_b;
    int           pend_cnt = 0;

    modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x      (in_x),
        .in_e      (in_e),
        .in_m      (in_m),
        .in_r2     (in_r2),
        .in_r      (in_r),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done),
        .result    (result),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // -M^-1 mod 2^W by Newton iteration (each step doubles the number of correct low bits).
    function automatic logic [W-1:0] mont_mp(input logic [W-1:0] m);
        logic [W-1:0] inv;
        inv = m;
        for (int k = 0; k < 10; k++) inv = inv * (W'(2) - m * inv);
        return '0 - inv;
    endfunction

    // a * b * 2^-W mod m (Montgomery REDC).
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m, input logic [W-1:0] mp);
        logic [2*W-1:0] t;
        logic [W-1:0]   u;
        logic [2*W+1:0] s;
        t = (2*W)'(a) * (2*W)'(b);
        u = t[W-1:0] * mp;
        s = (2*W+2)'(t) + (2*W+2)'(u) * (2*W+2)'(m);
        s = s >> W;
        if (s >= (2*W+2)'(m)) s = s - (2*W+2)'(m);
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] golden(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] acc, mm;
        mm  = (2*W)'(m);
        acc = (2*W)'(1) % mm;
        for (int i = EW - 1; i >= 0; i--) begin
            acc = (acc * acc) % mm;
            if (e[i]) acc = (acc * (2*W)'(x)) % mm;
        end
        return acc[W-1:0];
    endfunction

    function automatic int exp_pulses(input logic [EW-1:0] e);
        int pc;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        int msb;
        msb = -1;
        for (int i = 0; i < EW; i++) if (e[i]) msb = i;
        pc = $countones(e);
        return (msb < 0) ? 2 : 2 + msb + pc;
`else
        pc = $countones(e);
        return 2 + EW + pc;
`endif
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Multiplier model: mm_done stays high between operations, random 3..20-cycle latency.
    always @(negedge clk) begin
        if (!resetn) begin
            pend_cnt = 0;
            mm_done  = 1'b1;
        end else if (mm_start) begin
            pulses++;
            if (mm_m !== cur_m) stab_err++;
            pend_a    = mm_a;
            pend_b    = mm_b;
            pend_val  = mont(mm_a, mm_b, cur_m, cur_mp);
            pend_cnt  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 20) : 3;
            mm_done   = 1'b0;
            mm_result = ~pend_val;
        end else if (pend_cnt > 0) begin
            if (mm_a !== pend_a || mm_b !== pend_b) stab_err++;
            pend_cnt--;
            if (pend_cnt == 0) begin
                mm_result = pend_val;
                mm_done   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (low 64 bits)", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic load_inputs(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [W-1:0] m);
        logic [2*W:0] rr;
        logic [W-1:0] r;
        rr     = (2*W+1)'(1) << W;
        r      = W'(rr % (2*W+1)'(m));
        cur_m  = m;
        cur_mp = mont_mp(m);
        in_x   = x;
        in_e   = e;
        in_m   = m;
        in_r   = r;
        in_r2  = W'(((2*W)'(r) * (2*W)'(r)) % (2*W)'(m));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input logic [W-1:0] expect_res, input bit noise);
        int p0, d0;
        bit seen;
        load_inputs(x, e, m);
        p0    = pulses;
        d0    = done_cnt;
        seen  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, W'(busy), W'(1));
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (noise && (c % 300 == 150)) begin
                start = 1'b1;
                in_x  = rand_wide();
                in_e  = rand_wide();
                in_m  = rand_wide() | W'(1);
            end else begin
                start = 1'b0;
            end
        end
        check({name, "_done_seen"}, W'(seen), W'(1));
        check({name, "_result"}, result, expect_res);
        // A start coinciding with the internal DONE cycle must be dropped.
        start = noise;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_idle_after_done"}, W'(busy), W'(0));
        check({name, "_result_hold"}, result, expect_res);
        check({name, "_pulses"}, W'(pulses - p0), W'(exp_pulses(e)));
        check({name, "_done_count"}, W'(done_cnt - d0), W'(1));
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  x, m, g;
        logic [EW-1:0] e;
        int            p0, d0;

        resetn = 1'b0;
        start  = 1'b0;
        load_inputs(W'(5), EW'(3), W'(13));
        repeat (3) @(negedge clk);
        check("reset_mm_start", W'(mm_start), W'(0));
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_result", result, W'(0));
        check("reset_mm_a", mm_a, W'(0));
        check("reset_mm_b", mm_b, W'(0));
        check("reset_mm_m", mm_m, W'(0));
        resetn = 1'b1;
        @(negedge clk);

        run_op("t1_e3", W'(5), EW'(3), W'(13), W'(8), 1'b0);
        run_op("t2_e0", W'(5), EW'(0), W'(13), W'(1), 1'b0);
        run_op("t3_e1_busy_start", W'(7), EW'(1), W'(13), W'(7), 1'b1);

        for (int k = 0; k < 3; k++) begin
            m       = rand_wide();
            m[W-1]  = 1'b1;
            m[0]    = 1'b1;
            x       = rand_wide() % m;
            e       = rand_wide();
            g       = golden(x, e, m);
            run_op($sformatf("rand%0d", k), x, e, m, g, 1'b0);
        end

        // Abort mid-SQUARE: the third multiply of E=3 is a square in both build variants.
        load_inputs(W'(5), EW'(3), W'(13));
        p0    = pulses;
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && (pulses - p0) < 3; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t6_reached_square", W'(pulses - p0), W'(3));
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("t6_reset_mm_start", W'(mm_start), W'(0));
        check("t6_reset_busy", W'(busy), W'(0));
        check("t6_reset_done", W'(done), W'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("t6_no_done_on_abort", W'(done_cnt - d0), W'(0));
        run_op("t6_rerun", W'(5), EW'(3), W'(13), W'(8), 1'b0);

        check("operand_stability", W'(stab_err), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
